// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: credit-based skid FIFO that terminates a valid/ready stream whose ready path is pipelined.
// Define STREAM_SKID_FIFO_HWM_EN to add the high-water-mark output hwm.
module stream_skid_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int SKID   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   us_valid,
    input  logic [DATA_W-1:0]      us_data,
    output logic                   us_ready,
    output logic                   ds_valid,
    output logic [DATA_W-1:0]      ds_data,
    input  logic                   ds_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`ifdef STREAM_SKID_FIFO_HWM_EN
    ,
    output logic [$clog2(DEPTH):0] hwm
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_next;
    logic pop, push, load, mem_empty, mem_rd, mem_wr;
    // level counts the output register too, so the memory is empty when only that register is occupied
    always_comb begin
        pop        = ds_valid && ds_ready;
        push       = us_valid && (level < LW'(DEPTH) || pop);
        level_next = level + LW'(push) - LW'(pop);
        mem_empty  = level == LW'(ds_valid);
        load       = !ds_valid || pop;
        mem_rd     = load && !mem_empty;
        mem_wr     = push && !(load && mem_empty);
    end
    always_ff @(posedge clk)
        if (mem_wr) mem[wr_ptr] <= us_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            us_ready <= 1'b0;
            overflow <= 1'b0;
            ds_valid <= 1'b0;
            ds_data  <= '0;
        end else begin
            level    <= level_next;
            us_ready <= level_next <= LW'(DEPTH - SKID - 1);
            overflow <= overflow || (us_valid && !push);
            if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
            if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
            if (load) begin
                ds_valid <= push || !mem_empty;
                if (!mem_empty) ds_data <= mem[rd_ptr];
                else if (push) ds_data <= us_data;
            end
        end
    end
`ifdef STREAM_SKID_FIFO_HWM_EN
    always_ff @(posedge clk) begin
        if (rst) hwm <= '0;
        else if (level_next > hwm) hwm <= level_next;
    end
`endif
endmodule
